// File: rtl/ball_renderer.sv
// ball_renderer: bouncing-ball sprite overlay driven by an external sync generator.
// Ports: clk/reset (async, active-high); hpos/vpos/display_on/hsync/vsync from
// the sync generator; enable freezes motion when low; hsync_out/vsync_out/rgb/
// ball_gfx are the one-cycle-delayed, aligned video outputs; bounce_count is a
// saturating bounce counter; corner_hit pulses when both axes bounce together.
module ball_renderer #(
   parameter int BALL_SIZE = 4,
   parameter int H_MAX     = 256,
   parameter int V_MAX     = 240,
   parameter int X_INIT    = 128,
   parameter int Y_INIT    = 128,
   parameter int X_SPEED   = 2,
   parameter int Y_SPEED   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] hpos,
   input  logic [8:0] vpos,
   input  logic       display_on,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       enable,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic [2:0] rgb,
   output logic       ball_gfx,
   output logic [7:0] bounce_count,
   output logic       corner_hit
);
   localparam logic [9:0] X_LIM = 10'(H_MAX - BALL_SIZE);
   localparam logic [9:0] Y_LIM = 10'(V_MAX - BALL_SIZE);
   localparam logic [9:0] XS    = 10'(X_SPEED);
   localparam logic [9:0] YS    = 10'(Y_SPEED);
   localparam logic [8:0] BS    = 9'(BALL_SIZE);
   logic [8:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d, dx, dy;
   logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic       vsync_q, armed_q, move, x_bounce, y_bounce, hit;
   logic [9:0] x_ext, y_ext, x_next, y_next;
   logic [7:0] count_q, count_d;
   logic       corner_q, gfx_q, hs_q, vs_q;
   logic [2:0] rgb_q;
   // armed_q blocks a tick until vsync has been seen low after reset, so a
   // vsync that is already high when reset releases is not taken as an edge.
   always_comb begin
      move     = vsync & ~vsync_q & armed_q & enable;
      x_ext    = {1'b0, ball_x_q};
      y_ext    = {1'b0, ball_y_q};
      x_bounce = dir_x_q ? (x_ext < XS) : (x_ext + XS >= X_LIM);
      y_bounce = dir_y_q ? (y_ext < YS) : (y_ext + YS >= Y_LIM);
      x_next   = dir_x_q ? (x_bounce ? 10'd0 : x_ext - XS) : (x_bounce ? X_LIM : x_ext + XS);
      y_next   = dir_y_q ? (y_bounce ? 10'd0 : y_ext - YS) : (y_bounce ? Y_LIM : y_ext + YS);
      ball_x_d = move ? 9'(x_next) : ball_x_q;
      ball_y_d = move ? 9'(y_next) : ball_y_q;
      dir_x_d  = dir_x_q ^ (move & x_bounce);
      dir_y_d  = dir_y_q ^ (move & y_bounce);
      count_d  = (move & (x_bounce | y_bounce) & (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
      // Modular difference: beam positions left of / above the ball wrap large.
      dx       = hpos - ball_x_q;
      dy       = vpos - ball_y_q;
      hit      = (dx < BS) & (dy < BS);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ball_x_q <= 9'(X_INIT);
         ball_y_q <= 9'(Y_INIT);
         dir_x_q  <= 1'b0;
         dir_y_q  <= 1'b0;
         vsync_q  <= 1'b0;
         armed_q  <= 1'b0;
         count_q  <= 8'd0;
         corner_q <= 1'b0;
         gfx_q    <= 1'b0;
         rgb_q    <= 3'b000;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
      end else begin
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         vsync_q  <= vsync;
         armed_q  <= armed_q | ~vsync;
         count_q  <= count_d;
         corner_q <= move & x_bounce & y_bounce;
         gfx_q    <= hit & display_on;
         rgb_q    <= {3{hit & display_on}};
         hs_q     <= hsync;
         vs_q     <= vsync;
      end
   end
   assign hsync_out    = hs_q;
   assign vsync_out    = vs_q;
   assign rgb          = rgb_q;
   assign ball_gfx     = gfx_q;
   assign bounce_count = count_q;
   assign corner_hit   = corner_q;
endmodule

// File: tb/tb_ball_renderer.sv
// tb_ball_renderer: scoreboard bench for ball_renderer against a frame-level motion model.
module tb_ball_renderer;
   localparam int BS = 4, HM = 256, VM = 240, XI = 128, YI = 128, XSP = 2, YSP = 2;
   logic       clk = 1'b0, reset = 1'b1;
   logic [8:0] hpos = '0, vpos = '0;
   logic       display_on = 1'b0, hsync = 1'b0, vsync = 1'b0, enable = 1'b1;
   logic       hsync_out, vsync_out, ball_gfx, corner_hit;
   logic [2:0] rgb;
   logic [7:0] bounce_count;
   ball_renderer #(.BALL_SIZE(BS), .H_MAX(HM), .V_MAX(VM), .X_INIT(XI), .Y_INIT(YI),
                   .X_SPEED(XSP), .Y_SPEED(YSP)) dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .hsync(hsync), .vsync(vsync), .enable(enable), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .rgb(rgb), .ball_gfx(ball_gfx),
      .bounce_count(bounce_count), .corner_hit(corner_hit));
   always #5 clk = ~clk;
   logic [14:0] q[$];
   int n_chk = 0, n_fail = 0, seen = 0;
   int mx = XI, my = YI, mcnt = 0, nb = 0, m_corners = 0;
   bit mdx = 0, mdy = 0, mvq = 0, marm = 0;
   event dir_ev;
   string d_nm;
   logic [31:0] d_act, d_exp;
   always begin
      @(posedge clk or dir_ev);
      if (clk) begin
         #1;
         if (q.size() != 0) begin
            logic [14:0] e, a;
            e = q.pop_front();
            a = {hsync_out, vsync_out, rgb, ball_gfx, corner_hit, bounce_count};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL out t=%0t act hs=%b vs=%b rgb=%b gfx=%b corner=%b cnt=%0d exp hs=%b vs=%b rgb=%b gfx=%b corner=%b cnt=%0d",
                        $time, a[14], a[13], a[12:10], a[9], a[8], a[7:0],
                        e[14], e[13], e[12:10], e[9], e[8], e[7:0]);
            end
            if (corner_hit) seen++;
         end
      end else begin
         n_chk++;
         if (d_act !== d_exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d", d_nm, d_act, d_exp);
         end
      end
   end
   task automatic direct(input string nm, input logic [31:0] a, input logic [31:0] e);
      d_nm = nm; d_act = a; d_exp = e;
      -> dir_ev;
      #1;
   endtask
   // One axis of motion for one frame: advance by the speed, or clamp at the wall and reverse.
   task automatic step(inout int p, inout bit d, input int lim, input int sp, output bit b);
      b = 0;
      if (!d) begin
         if (p + sp >= lim - BS) begin p = lim - BS; d = 1; b = 1; end
         else p = p + sp;
      end else begin
         if (p < sp) begin p = 0; d = 0; b = 1; end
         else p = p - sp;
      end
   endtask
   task automatic drive(input bit rs, input bit vs, input bit en, input logic [8:0] h,
                        input logic [8:0] v, input bit de);
      bit hit, bx, by, cn;
      @(negedge clk);
      reset = rs; vsync = vs; enable = en; hpos = h; vpos = v; display_on = de;
      hsync = 1'($urandom_range(0, 1));
      if (rs) begin
         mx = XI; my = YI; mdx = 0; mdy = 0; mcnt = 0; mvq = 0; marm = 0;
         q.push_back(15'd0);
      end else begin
         hit = (int'(h) >= mx) && (int'(h) < mx + BS) && (int'(v) >= my) && (int'(v) < my + BS);
         bx = 0; by = 0; cn = 0;
         if (vs && !mvq && marm && en) begin
            step(mx, mdx, HM, XSP, bx);
            step(my, mdy, VM, YSP, by);
            if (bx || by) begin nb++; if (mcnt < 255) mcnt++; end
            cn = bx && by;
            if (cn) m_corners++;
         end
         marm = marm || !vs;
         mvq = vs;
         q.push_back({hsync, vs, {3{hit && de}}, hit && de, cn, 8'(mcnt)});
      end
   endtask
   function automatic logic [8:0] near(input int c);
      return 9'(c - 2 + int'($urandom_range(0, 7)));
   endfunction
   task automatic frame(input bit en);
      drive(0, 1, en, near(mx), near(my), 1'($urandom_range(0, 3) != 0));
      drive(0, 0, en, near(mx), near(my), 1'($urandom_range(0, 3) != 0));
   endtask
   task automatic sweep(input int a, input int b, input logic [8:0] v, input bit vs, input bit de);
      for (int h = a; h <= b; h++) drive(0, vs, 1, 9'(h), v, de);
   endtask
   task automatic imm_rst();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 direct("reset_async", 32'({rgb, ball_gfx, hsync_out, vsync_out, corner_hit, bounce_count}), 32'd0);
   endtask
   initial begin
      drive(1, 0, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) frame(1);
      sweep(132, 139, 9'd135, 0, 1);
      for (int i = 0; i < 10; i++) frame(0);
      sweep(132, 139, 9'd135, 0, 1);
      for (int i = 0; i < 5; i++) frame(1);
      imm_rst();
      drive(1, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      sweep(126, 133, 9'd129, 0, 1);
      sweep(126, 133, 9'd129, 0, 0);
      drive(0, 1, 1, near(mx), near(my), 1);
      imm_rst();
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 1, near(mx), near(my), 1);
      sweep(126, 133, 9'd129, 1, 1);
      drive(0, 0, 1, near(mx), near(my), 1);
      drive(0, 1, 1, near(mx), near(my), 1);
      sweep(128, 135, 9'd131, 1, 1);
      for (int f = 0; f < 25000 && (nb < 300 || m_corners == 0); f++) frame(1);
      drive(0, 0, 1, near(mx), near(my), 1);
      drive(0, 0, 1, near(mx), near(my), 1);
      @(negedge clk);
      #1 direct("count_sat", 32'(bounce_count), 32'd255);
      direct("corner_pulses", 32'(seen), 32'(m_corners));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  BALL_SIZE  4    ball edge length, pixels
  H_MAX      256  visible width; right limit
  V_MAX      240  visible height; bottom limit
  X_INIT     128  ball X after reset
  Y_INIT     128  ball Y after reset
  X_SPEED    2    horizontal step per frame
  Y_SPEED    2    vertical step per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk           in   1  single clock
  reset         in   1  asynchronous, active-high reset
  hpos          in   9  current beam column from the sync generator
  vpos          in   9  current beam row from the sync generator
  display_on    in   1  beam in visible area
  hsync         in   1  horizontal sync from the sync generator
  vsync         in   1  vertical sync from the sync generator
  enable        in   1  1 = ball moves each frame, 0 = ball frozen
  hsync_out     out  1  hsync delayed to align with rgb
  vsync_out     out  1  vsync delayed to align with rgb
  rgb           out  3  pixel colour {b,g,r}
  ball_gfx      out  1  beam inside ball square (aligned with rgb)
  bounce_count  out  8  saturating count of bounce events
  corner_hit    out  1  one-cycle pulse on simultaneous X and Y bounce

Function
REQ-003 Frame tick SHALL be vsync rising edge: vsync registered once, tick = vsync & ~vsync_q; exactly one tick per frame.
REQ-004 State SHALL be ball_x[8:0], ball_y[8:0], dir_x (0 = right/+), dir_y (0 = down/+).
REQ-005 Position SHALL update only in the cycle after a tick with enable=1; otherwise ball_x, ball_y, dir_x, dir_y hold.
REQ-006 Position arithmetic SHALL be 10-bit unsigned, so no intermediate wraps through 9-bit overflow.
REQ-007 Moving right: if ball_x + X_SPEED >= H_MAX - BALL_SIZE, ball_x SHALL clamp to H_MAX - BALL_SIZE and dir_x SHALL flip to 1; else ball_x += X_SPEED.
REQ-008 Moving left: if ball_x < X_SPEED, ball_x SHALL clamp to 0 and dir_x SHALL flip to 0; else ball_x -= X_SPEED.
REQ-009 Y axis SHALL follow REQ-007/008 using ball_y, Y_SPEED, V_MAX and dir_y.
REQ-010 Each tick with at least one axis bounce SHALL increment bounce_count by exactly 1, including a tick where both axes bounce; bounce_count SHALL saturate at 255.
REQ-011 corner_hit SHALL be 1 for exactly the one cycle in which the position update has both axes bouncing; otherwise 0.
REQ-012 Hit test SHALL be unsigned 9-bit: hit = ((hpos - ball_x) < BALL_SIZE) & ((vpos - ball_y) < BALL_SIZE); pixels left of or above the ball SHALL wrap large and miss.
REQ-013 Outputs ball_gfx, rgb, hsync_out and vsync_out SHALL be registered with 1-cycle latency from hpos/vpos/display_on/hsync/vsync.
REQ-014 ball_gfx SHALL be hit & display_on.
REQ-015 rgb SHALL be 3'b111 when ball_gfx, 3'b000 otherwise; rgb SHALL be 3'b000 whenever display_on was 0.
REQ-016 A position update and the hit test in the same cycle SHALL use the pre-update ball_x/ball_y.

Reset
REQ-017 Reset asserted SHALL immediately, without a clock, force: ball_x = X_INIT, ball_y = Y_INIT, dir_x = dir_y = 0, bounce_count = 0, corner_hit = 0, ball_gfx = 0, rgb = 0, hsync_out = vsync_out = 0, vsync_q = 0.
REQ-018 Reset asserted mid-frame or mid-update SHALL discard any pending tick.
REQ-019 After reset deasserts, the first tick SHALL require a fresh vsync 0 -> 1 transition seen at a clock edge.

Verification
REQ-020 The bench SHALL cover these scenarios:
  - Reset, enable=1, 3 vsync pulses -> ball_x=134, ball_y=134, bounce_count=0.
  - ball_x=250 moving right, one tick -> ball_x=252, dir_x=1, bounce_count +1; next tick -> ball_x=250.
  - ball_x=250 and ball_y=234, both moving +, one tick -> corner_hit high for 1 cycle, bounce_count +1 (not +2).
  - enable=0 across 10 ticks -> position, dirs and count unchanged.
  - Ball at (128,128), sweep hpos 126..133 on vpos=129 with display_on=1 -> rgb=111 exactly one cycle after hpos=128..131 are presented, else 000; same sweep with display_on=0 -> rgb=000.
  - Reset pulse while vsync=1, release, keep vsync=1 -> no tick until vsync falls and rises again; bounce_count held at 255 after 300 bounces.
